// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 5;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } muldiv_state_e;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: shift-add multiply and restoring divide,
// one bit per cycle, sharing counter, accumulator and sign fix-up.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN = muldiv_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam logic [XLEN-1:0]  ALL_ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_LAST = {CNT_W{1'b1}};

    muldiv_state_e     state_q,  state_d;
    muldiv_op_e        op_q,     op_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;
    logic [2*XLEN-1:0] acc_q,    acc_d;
    logic [XLEN-1:0]   b_q,      b_d;
    logic              qneg_q,   qneg_d;
    logic              rneg_q,   rneg_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              busy_q,   busy_d;
    logic              done_q,   done_d;

    // Operand decode at accept
    muldiv_op_e      op_in;
    logic            is_div, a_signed, b_signed, sa, sb, div_zero, div_ovf;
    logic [XLEN-1:0] a_mag, b_mag;

    assign op_in    = muldiv_op_e'(funct3);
    assign is_div   = funct3[2];
    assign a_signed = (op_in == OP_MULH) || (op_in == OP_MULHSU) ||
                      (op_in == OP_DIV)  || (op_in == OP_REM);
    assign b_signed = (op_in == OP_MULH) || (op_in == OP_DIV) || (op_in == OP_REM);
    assign sa       = a_signed & operand_a[XLEN-1];
    assign sb       = b_signed & operand_b[XLEN-1];
    assign a_mag    = sa ? (-operand_a) : operand_a;
    assign b_mag    = sb ? (-operand_b) : operand_b;
    assign div_zero = is_div && (operand_b == '0);
    assign div_ovf  = is_div && b_signed && (operand_a == INT_MIN) && (operand_b == ALL_ONES);

    // One iteration step: acc holds {hi, lo} for multiply, {remainder, quotient} for divide
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_shift;
    logic [XLEN+1:0] div_diff;

    assign mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
    assign div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    assign div_diff  = {1'b0, div_shift} - {2'b00, b_q};

    // Sign fix-up and word select
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot_fix, rem_fix, fix_word;

    assign prod_fix = qneg_q ? (-acc_q) : acc_q;
    assign quot_fix = qneg_q ? (-acc_q[XLEN-1:0]) : acc_q[XLEN-1:0];
    assign rem_fix  = rneg_q ? (-acc_q[2*XLEN-1:XLEN]) : acc_q[2*XLEN-1:XLEN];

    always_comb begin
        fix_word = '0;
        case (op_q)
            OP_MUL:                       fix_word = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_word = prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              fix_word = quot_fix;
            OP_REM, OP_REMU:              fix_word = rem_fix;
            default:                      fix_word = '0;
        endcase
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        b_d      = b_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        result_d = result_q;

        case (state_q)
            RUN: begin
                if (op_q[2]) begin
                    if (!div_diff[XLEN+1]) begin
                        acc_d = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
                    end else begin
                        acc_d = {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
                    end
                end else begin
                    acc_d = {mul_sum, acc_q[XLEN-1:1]};
                end
                if (cnt_q == CNT_LAST) begin
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            FIX: begin
                result_d = fix_word;
                state_d  = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = state_q;
        endcase

        if (flush) begin
            state_d  = IDLE;
            result_d = result_q;
        end else if (start && ((state_q == IDLE) || (state_q == DONE))) begin
            op_d  = op_in;
            cnt_d = '0;
            b_d   = b_mag;
            if (div_zero) begin
                // Raw results bypass the sign fix-up
                acc_d   = {operand_a, ALL_ONES};
                qneg_d  = 1'b0;
                rneg_d  = 1'b0;
                state_d = FIX;
            end else if (div_ovf) begin
                acc_d   = {{XLEN{1'b0}}, INT_MIN};
                qneg_d  = 1'b0;
                rneg_d  = 1'b0;
                state_d = FIX;
            end else begin
                acc_d   = {{XLEN{1'b0}}, a_mag};
                qneg_d  = sa ^ sb;
                rneg_d  = sa;
                state_d = RUN;
            end
        end

        busy_d = (state_d == RUN) || (state_d == FIX);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= OP_MUL;
            cnt_q    <= '0;
            acc_q    <= '0;
            b_q      <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            b_q      <= b_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed corner cases, control scenarios
// and randomized back-to-back operations against an arithmetic reference.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;

    muldiv_unit #(.XLEN(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .funct3    (funct3),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .flush     (flush),
        .busy      (busy),
        .done      (done),
        .result    (result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        int          due;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   errors   = 0;
    int   checks   = 0;
    int   done_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // RISC-V M-extension semantics computed with plain wide arithmetic
    function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        logic signed [63:0] sa64, sb64;
        logic        [63:0] p;
        logic signed [31:0] as32, bs32;
        logic               ovf;
        as32 = a;
        bs32 = b;
        ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p    = 64'd0;
        case (op)
            3'd0: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
            3'd1: begin
                sa64 = {{32{a[31]}}, a}; sb64 = {{32{b[31]}}, b};
                p = sa64 * sb64; return p[63:32];
            end
            3'd2: begin
                sa64 = {{32{a[31]}}, a}; sb64 = {32'd0, b};
                p = sa64 * sb64; return p[63:32];
            end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(as32 / bs32);
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : ovf ? 32'd0 : 32'(as32 % bs32);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic fast;
        fast = op[2] && ((b == 0) ||
               (!op[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)));
        return fast ? 2 : 34;
    endfunction

    // Monitor: every done pulse is matched to the oldest expected response
    always @(negedge clk) begin
        if (rst_n && done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_done: got done at cycle %0d expected none", cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check(e.name, result, e.res);
                checks++;
                if (cyc != e.due) begin
                    errors++;
                    $display("FAIL %s_latency: got done at cycle %0d expected %0d", e.name, cyc, e.due);
                end
            end
        end
    end

    // Called at a negedge; returns one negedge after driving start
    task automatic issue(input string name, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input bit push, input logic [31:0] expv);
        int n;
        n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL %s_ready_timeout: got busy after %0d cycles expected idle", name, n);
        end
        start     = 1'b1;
        funct3    = op;
        operand_a = a;
        operand_b = b;
        if (push) exp_q.push_back('{res: expv, due: cyc + latency(op, a, b), name: name});
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_drain_timeout: got %0d pending expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected completion");
        $fatal(1);
    end

    initial begin
        int          bc, d0;
        logic [31:0] prev, ra, rb;
        logic [2:0]  rop;

        rst_n = 1'b0; start = 1'b0; flush = 1'b0;
        funct3 = 3'd0; operand_a = 32'd0; operand_b = 32'd0;
        repeat (3) @(negedge clk);
        check("reset_busy",   32'(busy),  32'd0);
        check("reset_done",   32'(done),  32'd0);
        check("reset_result", result,     32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // MUL 7 x -3 with busy profile
        issue("mul_7_m3", 3'd0, 32'd7, 32'hFFFF_FFFD, 1'b1, 32'hFFFF_FFEB);
        bc = 0;
        repeat (34) begin
            if (busy) bc++;
            @(negedge clk);
        end
        check("mul_busy_cycles", 32'(bc), 32'd33);
        drain("mul_7_m3");

        // Directed corners, issued back-to-back
        issue("mulhu_ff",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE);
        issue("mulh_ff",   3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000);
        issue("mulhsu_ff", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF);
        issue("div_m7_2",  3'd4, 32'hFFFF_FFF9, 32'd2,         1'b1, 32'hFFFF_FFFD);
        issue("rem_m7_2",  3'd6, 32'hFFFF_FFF9, 32'd2,         1'b1, 32'hFFFF_FFFF);
        issue("divu_100_7",3'd5, 32'd100,       32'd7,         1'b1, 32'd14);
        issue("remu_100_7",3'd7, 32'd100,       32'd7,         1'b1, 32'd2);
        issue("divu_5_0",  3'd5, 32'd5,         32'd0,         1'b1, 32'hFFFF_FFFF);
        issue("rem_5_0",   3'd6, 32'd5,         32'd0,         1'b1, 32'd5);
        issue("div_ovf",   3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000);
        issue("rem_ovf",   3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0);
        issue("mul_after", 3'd0, 32'd1234,      32'd5678,      1'b1, 32'd7006652);
        drain("directed");

        // start during RUN is ignored
        d0 = done_cnt;
        issue("divu_ign", 3'd5, 32'd1000, 32'd3, 1'b1, 32'd333);
        repeat (9) @(negedge clk);
        start = 1'b1; funct3 = 3'd0; operand_a = 32'd9; operand_b = 32'd9;
        @(negedge clk);
        start = 1'b0;
        drain("divu_ign");
        repeat (5) @(negedge clk);
        check("ignored_start_dones", 32'(done_cnt - d0), 32'd1);

        // flush mid-op
        prev = result;
        d0   = done_cnt;
        issue("div_flush", 3'd4, 32'd77, 32'd5, 1'b0, 32'd0);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", 32'(busy), 32'd0);
        repeat (40) @(negedge clk);
        check("flush_no_done", 32'(done_cnt - d0), 32'd0);
        check("flush_result",  result, prev);

        // asynchronous reset mid-DIV
        issue("div_rst", 3'd4, 32'd500, 32'd7, 1'b0, 32'd0);
        repeat (14) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy",   32'(busy), 32'd0);
        check("arst_done",   32'(done), 32'd0);
        check("arst_result", result,    32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue("mul_3_4", 3'd0, 32'd3, 32'd4, 1'b1, 32'd12);
        drain("mul_3_4");

        // randomized back-to-back stream
        for (int i = 0; i < 150; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = pick();
            rb  = pick();
            issue($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb, 1'b1, ref_model(rop, ra, rb));
        end
        drain("random");
        repeat (5) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
